// File: rtl/load_store_unit.sv
// load_store_unit
//   Multi-cycle RV32I load/store unit. Turns a core access (addr, funct3,
//   store data, direction) into one word-aligned handshaked bus transaction
//   with byte enables. It holds the core stalled until the transaction ends.
//   Load data is returned sign- or zero-extended.
//   Misaligned/illegal accesses and bus timeouts are reported in DONE.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   mem_read/mem_write  access request from the core (held stable while stall)
//   funct3, addr, wdata access size/sign, byte address, store data
//   rdata               extended load data, non-zero only in DONE
//   stall               core hold request
//   misaligned, bus_err one-cycle error pulses in DONE
//   m_valid/m_ready     request handshake; m_we, m_addr, m_be, m_wdata payload
//   m_rvalid/m_rdata    read response, honoured only while waiting in RESP
module load_store_unit #(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        misaligned,
  output logic        bus_err,
  output logic        m_valid,
  input  logic        m_ready,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [3:0]  m_be,
  output logic [31:0] m_wdata,
  input  logic        m_rvalid,
  input  logic [31:0] m_rdata
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

  state_t             r_state;
  state_t             w_next;
  logic [CNT_W-1:0]   r_cnt;
  logic [31:0]        r_addr;
  logic [31:0]        r_wdata;
  logic [31:0]        r_rdata;
  logic [2:0]         r_funct3;
  logic               r_we;
  logic               r_mis;
  logic               r_tmo;

  logic               w_req;
  logic               w_err;
  logic               w_last;
  logic [1:0]         w_off;
  logic [3:0]         w_be;
  logic [31:0]        w_wdata_rep;
  logic [31:0]        w_load;
  logic [7:0]         w_byte;
  logic [15:0]        w_half;

  assign w_req  = mem_read | mem_write;
  assign w_off  = r_addr[1:0];
  // Last allowed wait cycle: the TIMEOUT-th cycle spent in REQ or RESP.
  assign w_last = (r_cnt == CNT_W'(TIMEOUT - 1));

  // Error check on the live core inputs, evaluated while IDLE.
  always_comb begin
    w_err = 1'b0;
    case (funct3)
      3'b000, 3'b001, 3'b010: w_err = 1'b0;
      3'b100, 3'b101:         w_err = mem_write;  // unsigned forms exist for loads only
      default:                w_err = 1'b1;
    endcase
    if (funct3[1:0] == 2'b01 && addr[0])           w_err = 1'b1;
    if (funct3[1:0] == 2'b10 && addr[1:0] != 2'b00) w_err = 1'b1;
    if (mem_read && mem_write)                     w_err = 1'b1;
  end

  // Byte enables and lane-replicated store data from the latched access.
  always_comb begin
    case (r_funct3[1:0])
      2'b00: begin
        w_be        = 4'b0001 << w_off;
        w_wdata_rep = {4{r_wdata[7:0]}};
      end
      2'b01: begin
        w_be        = 4'b0011 << w_off;
        w_wdata_rep = {2{r_wdata[15:0]}};
      end
      default: begin
        w_be        = 4'b1111;
        w_wdata_rep = r_wdata;
      end
    endcase
  end

  // Load lane extraction and extension from the captured response word.
  assign w_byte = r_rdata[{w_off, 3'b000} +: 8];
  assign w_half = r_rdata[{r_addr[1], 4'b0000} +: 16];

  always_comb begin
    case (r_funct3)
      3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_load = {{16{w_half[15]}}, w_half};
      3'b100:  w_load = {24'd0, w_byte};
      3'b101:  w_load = {16'd0, w_half};
      default: w_load = r_rdata;
    endcase
  end

  // Control state: FSM, wait counter, direction and result flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_mis   <= 1'b0;
      r_tmo   <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: begin
          if (w_req) begin
            r_we  <= mem_write;
            r_mis <= w_err;
            r_tmo <= 1'b0;
            r_cnt <= '0;
          end
        end
        REQ: begin
          if (m_ready)     r_cnt <= '0;  // fresh wait budget for RESP
          else if (w_last) r_tmo <= 1'b1;
          else             r_cnt <= r_cnt + CNT_W'(1);
        end
        RESP: begin
          if (m_rvalid)    r_cnt <= r_cnt;
          else if (w_last) r_tmo <= 1'b1;
          else             r_cnt <= r_cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Access payload; never observed outside the states that qualify it.
  always_ff @(posedge clk) begin
    if (r_state == IDLE && w_req) begin
      r_addr   <= addr;
      r_funct3 <= funct3;
      r_wdata  <= wdata;
      r_rdata  <= '0;
    end else if (r_state == RESP && m_rvalid) begin
      r_rdata  <= m_rdata;
    end
  end

  // Next state and outputs.
  always_comb begin
    w_next     = r_state;
    stall      = 1'b0;
    m_valid    = 1'b0;
    m_we       = 1'b0;
    m_addr     = '0;
    m_be       = '0;
    m_wdata    = '0;
    rdata      = '0;
    misaligned = 1'b0;
    bus_err    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_req) begin
          // Held low while reset is asserted; otherwise follows the request.
          stall  = ~rst;
          w_next = w_err ? DONE : REQ;
        end
      end
      REQ: begin
        stall   = 1'b1;
        m_valid = 1'b1;
        m_we    = r_we;
        m_addr  = {r_addr[31:2], 2'b00};
        m_be    = w_be;
        m_wdata = r_we ? w_wdata_rep : '0;
        if (m_ready)     w_next = r_we ? DONE : RESP;
        else if (w_last) w_next = DONE;
      end
      RESP: begin
        stall = 1'b1;
        if (m_rvalid || w_last) w_next = DONE;
      end
      DONE: begin
        misaligned = r_mis;
        bus_err    = r_tmo;
        rdata      = (r_mis || r_tmo || r_we) ? '0 : w_load;
        w_next     = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit: directed accesses followed by randomized
// traffic, checked against a byte-addressed memory model and access rules.
module tb_load_store_unit;

  localparam int TO = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read, mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata;
  logic [31:0] rdata;
  logic        stall, misaligned, bus_err;
  logic        m_valid, m_ready, m_we;
  logic [31:0] m_addr;
  logic [3:0]  m_be;
  logic [31:0] m_wdata;
  logic        m_rvalid;
  logic [31:0] m_rdata;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0]  ref_mem [0:63];   // reference: byte-addressed memory
  logic [31:0] bus_mem [0:15];   // bus slave storage, written via DUT requests

  load_store_unit #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .mem_read(mem_read), .mem_write(mem_write), .funct3(funct3),
    .addr(addr), .wdata(wdata),
    .rdata(rdata), .stall(stall), .misaligned(misaligned), .bus_err(bus_err),
    .m_valid(m_valid), .m_ready(m_ready), .m_we(m_we), .m_addr(m_addr),
    .m_be(m_be), .m_wdata(m_wdata), .m_rvalid(m_rvalid), .m_rdata(m_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int acc_size(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 1;
      2'b01:   return 2;
      default: return 4;
    endcase
  endfunction

  function automatic bit is_err(input bit rd, input bit wr, input logic [2:0] f3,
                                input logic [31:0] a);
    bit legal;
    if (rd && wr) return 1'b1;
    if (wr) legal = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2);
    else    legal = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    if (!legal) return 1'b1;
    if ((int'(a[1:0]) % acc_size(f3)) != 0) return 1'b1;
    return 1'b0;
  endfunction

  // One access from the core's point of view, with the bus slave accepting
  // after rdly wait cycles and answering a read rvdly cycles after accept.
  task automatic run_access(input bit rd, input bit wr, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] wd,
                            input int rdly, input int vdly,
                            output logic [31:0] got_rd);
    bit err, we, tmo_req, tmo, accepted, done;
    int sz, off, ereq, eresp, elat, nvalid, nresp, cyc;
    logic [31:0] eload, erdata, ewd, acc_addr;
    logic [3:0]  ebe;
    err = is_err(rd, wr, f3, a);
    we  = wr;
    sz  = acc_size(f3);
    off = int'(a[1:0]);
    for (int i = 0; i < 4; i++) begin
      ebe[i] = (i >= off) && (i < off + sz);
      ewd[8*i +: 8] = wd[8*(i % sz) +: 8];
    end
    eload = 32'd0;
    if (!err) begin
      for (int k = 0; k < sz; k++) eload[8*k +: 8] = ref_mem[int'(a[5:0]) + k];
      if (!f3[2] && sz == 1) eload = {{24{eload[7]}}, eload[7:0]};
      if (!f3[2] && sz == 2) eload = {{16{eload[15]}}, eload[15:0]};
    end
    tmo_req = !err && rdly >= TO;
    ereq    = err ? 0 : (tmo_req ? TO : rdly + 1);
    eresp   = (!err && !tmo_req && !we) ? ((vdly >= TO) ? TO : vdly + 1) : 0;
    tmo     = tmo_req || (eresp != 0 && vdly >= TO);
    elat    = 1 + ereq + eresp;
    erdata  = (err || tmo || we) ? 32'd0 : eload;
    if (!err && we && !tmo_req)
      for (int k = 0; k < sz; k++) ref_mem[int'(a[5:0]) + k] = wd[8*k +: 8];

    @(negedge clk);
    mem_read = rd; mem_write = wr; funct3 = f3; addr = a; wdata = wd;
    m_ready = 1'b0; m_rvalid = 1'b0;
    nvalid = 0; nresp = 0; accepted = 1'b0; done = 1'b0; acc_addr = 32'd0;
    for (cyc = 0; cyc <= 2*TO + 4; cyc++) begin
      #1;
      if (!stall) begin
        done = 1'b1;
        break;
      end
      chk("quiet", 64'({rdata, misaligned, bus_err}), 64'd0);
      if (m_valid) begin
        chk("m_addr", 64'(m_addr), 64'({a[31:2], 2'b00}));
        chk("m_be", 64'(m_be), 64'(ebe));
        chk("m_we", 64'(m_we), 64'(we));
        if (we) chk("m_wdata", 64'(m_wdata), 64'(ewd));
        if (nvalid == rdly) begin
          m_ready  = 1'b1;
          accepted = 1'b1;
          acc_addr = m_addr;
          if (m_we)
            for (int i = 0; i < 4; i++)
              if (m_be[i]) bus_mem[m_addr[5:2]][8*i +: 8] = m_wdata[8*i +: 8];
        end else begin
          m_ready = 1'b0;
        end
        m_rvalid = 1'($urandom_range(0, 1));   // must be ignored here
        m_rdata  = $urandom;
        nvalid++;
      end else if (accepted) begin
        m_ready = 1'($urandom_range(0, 1));
        if (nresp == vdly) begin
          m_rvalid = 1'b1;
          m_rdata  = bus_mem[acc_addr[5:2]];
        end else begin
          m_rvalid = 1'b0;
          m_rdata  = $urandom;
        end
        nresp++;
      end else begin
        m_ready  = 1'($urandom_range(0, 1));
        m_rvalid = 1'($urandom_range(0, 1));
        m_rdata  = $urandom;
      end
      @(negedge clk);
    end
    chk("done_seen", 64'(done), 64'd1);
    chk("latency", 64'(cyc), 64'(elat));
    chk("n_valid", 64'(nvalid), 64'(ereq));
    chk("misaligned", 64'(misaligned), 64'(err));
    chk("bus_err", 64'(bus_err), 64'(tmo));
    chk("rdata", 64'(rdata), 64'(erdata));
    chk("done_mvalid", 64'(m_valid), 64'd0);
    got_rd = rdata;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      mem_read = 1'b0; mem_write = 1'b0;
      m_ready  = 1'($urandom_range(0, 1));
      m_rvalid = 1'($urandom_range(0, 1));
      #1;
      chk("idle_stall", 64'(stall), 64'd0);
      chk("idle_mvalid", 64'(m_valid), 64'd0);
    end
  endtask

  // Reset hits a load waiting in REQ (in_resp=0) or RESP (in_resp=1).
  task automatic reset_mid(input bit in_resp);
    @(negedge clk);
    mem_read = 1'b1; mem_write = 1'b0; funct3 = 3'b010; addr = 32'h108;
    m_ready = 1'b0; m_rvalid = 1'b0;
    @(negedge clk);
    if (in_resp) begin
      m_ready = 1'b1;
      @(negedge clk);
      m_ready = 1'b0;
    end
    #1;
    chk("pre_rst_stall", 64'(stall), 64'd1);
    chk("pre_rst_mvalid", 64'(m_valid), 64'(!in_resp));
    #1 rst = 1'b1;
    #1;
    chk("rst_mvalid", 64'(m_valid), 64'd0);
    chk("rst_stall", 64'(stall), 64'd0);
    chk("rst_outs", 64'({rdata, misaligned, bus_err, m_we, m_be}), 64'd0);
    @(negedge clk);
    rst = 1'b0; mem_read = 1'b0;
    m_rvalid = 1'b1; m_rdata = $urandom;
    #1;
    chk("post_rst_stall", 64'(stall), 64'd0);
    chk("post_rst_mvalid", 64'(m_valid), 64'd0);
    @(negedge clk);
    m_rvalid = 1'b0;
    #1;
    chk("post_rst_outs", 64'({rdata, misaligned, bus_err, stall}), 64'd0);
  endtask

  initial begin
    logic [31:0] got, a, wd;
    bit rd, wr;
    logic [2:0] f3;
    int sel, r, rdly, vdly, sz;
    logic [2:0] rd_ok [0:4];
    logic [2:0] wr_ok [0:2];
    rd_ok[0] = 3'd0; rd_ok[1] = 3'd1; rd_ok[2] = 3'd2; rd_ok[3] = 3'd4; rd_ok[4] = 3'd5;
    wr_ok[0] = 3'd0; wr_ok[1] = 3'd1; wr_ok[2] = 3'd2;

    for (int i = 0; i < 64; i++) begin
      ref_mem[i] = 8'($urandom);
      bus_mem[i/4][8*(i%4) +: 8] = ref_mem[i];
    end

    rst = 1'b1;
    mem_read = 1'b1; mem_write = 1'b0; funct3 = 3'b010; addr = 32'h100; wdata = 32'd0;
    m_ready = 1'b0; m_rvalid = 1'b0; m_rdata = 32'd0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset_stall", 64'(stall), 64'd0);
    chk("reset_mvalid", 64'(m_valid), 64'd0);
    chk("reset_outs", 64'({rdata, misaligned, bus_err}), 64'd0);
    chk("reset_bus", 64'({m_we, m_be, m_addr}), 64'd0);
    @(negedge clk);
    rst = 1'b0; mem_read = 1'b0;
    idle_cycles(2);

    // Plan accesses
    run_access(0, 1, 3'b010, 32'h100, 32'hDEADBEEF, 0, 0, got);
    run_access(0, 1, 3'b010, 32'h100, 32'h80123456, 0, 0, got);
    run_access(1, 0, 3'b000, 32'h103, 32'd0, 0, 0, got);
    chk("lb_plan", 64'(got), 64'hFFFFFF80);
    run_access(1, 0, 3'b100, 32'h103, 32'd0, 0, 0, got);
    chk("lbu_plan", 64'(got), 64'h00000080);
    run_access(0, 1, 3'b001, 32'h202, 32'h0000ABCD, 0, 0, got);
    run_access(1, 0, 3'b001, 32'h202, 32'd0, 1, 2, got);
    chk("lh_plan", 64'(got), 64'hFFFFABCD);
    run_access(1, 0, 3'b101, 32'h202, 32'd0, 0, 0, got);
    chk("lhu_plan", 64'(got), 64'h0000ABCD);
    run_access(1, 0, 3'b010, 32'h101, 32'd0, 0, 0, got);
    idle_cycles(1);
    // Boundaries: timeout in REQ and in RESP, last legal wait, illegal forms
    run_access(0, 1, 3'b010, 32'h104, 32'h12345678, 1000, 0, got);
    run_access(1, 0, 3'b010, 32'h104, 32'd0, 0, 1000, got);
    run_access(1, 0, 3'b010, 32'h104, 32'd0, TO-1, TO-1, got);
    run_access(1, 1, 3'b010, 32'h104, 32'd0, 0, 0, got);
    run_access(0, 1, 3'b100, 32'h104, 32'd0, 0, 0, got);
    run_access(1, 0, 3'b011, 32'h104, 32'd0, 0, 0, got);
    // Reset in the middle of a transaction
    reset_mid(1'b0);
    reset_mid(1'b1);
    run_access(1, 0, 3'b010, 32'h108, 32'd0, 0, 0, got);

    for (int n = 0; n < 300; n++) begin
      sel = int'($urandom_range(0, 19));
      rd = (sel < 9) || (sel >= 18);
      wr = (sel >= 9);
      if ($urandom_range(0, 7) == 0) f3 = 3'($urandom);
      else if (wr)                    f3 = wr_ok[$urandom_range(0, 2)];
      else                            f3 = rd_ok[$urandom_range(0, 4)];
      a  = 32'h100 + 32'($urandom_range(0, 63));
      sz = acc_size(f3);
      if ($urandom_range(0, 1) == 1) a = a & ~32'(sz - 1);
      wd = $urandom;
      r = int'($urandom_range(0, 15));
      rdly = (r == 0) ? TO + int'($urandom_range(0, 2)) : (r == 1) ? TO - 1 : int'($urandom_range(0, 3));
      r = int'($urandom_range(0, 15));
      vdly = (r == 0) ? TO + int'($urandom_range(0, 2)) : (r == 1) ? TO - 1 : int'($urandom_range(0, 3));
      run_access(rd, wr, f3, a, wd, rdly, vdly, got);
      if ($urandom_range(0, 3) == 0) idle_cycles(1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Multi-cycle load/store unit between the core's datapath (ALU address, RD2 store data, control funct3) and a handshaked data-memory bus. It decodes RV32I byte, halfword and word accesses into word-aligned bus transactions with byte enables. It stalls the core while a transaction is outstanding and returns the sign- or zero-extended load result. Misaligned, illegal and timed-out accesses are flagged.

## Interface
Parameters:
- TIMEOUT, 15: maximum wait cycles in REQ or RESP before the access is aborted.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous, active-high.
- mem_read  in  1  the current instruction is a load.
- mem_write  in  1  the current instruction is a store.
- funct3  in  3  access size/sign: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu. For stores, only 000 sb, 001 sh and 010 sw are legal.
- addr  in  32  byte address (ALU result).
- wdata  in  32  store data (RD2).
- rdata  out  32  extended load data; valid in DONE only, 0 otherwise.
- stall  out  1  core must hold PC and all inputs stable while high.
- misaligned  out  1  one-cycle pulse in DONE for a misaligned or illegal access.
- bus_err  out  1  one-cycle pulse in DONE when the access timed out.
- m_valid  out  1  bus request valid.
- m_ready  in  1  bus accepts the request when m_valid && m_ready.
- m_we  out  1  1 = write request.
- m_addr  out  32  {addr[31:2],2'b00}.
- m_be  out  4  byte enables.
- m_wdata  out  32  lane-replicated store data.
- m_rvalid  in  1  read response valid; sampled only in RESP.
- m_rdata  in  32  read response word.

## Operation
- FSM states: IDLE, REQ, RESP, DONE.
- **IDLE**, with an access requested (mem_read or mem_write):
  - stall=1 combinationally.
  - Latch addr, funct3, wdata and direction.
  - If the access is an error, go to DONE with the error latched and issue no bus request.
  - Otherwise go to REQ.
- **Error conditions** detected in IDLE:
  - mem_read and mem_write both high.
  - Illegal funct3 for the direction.
  - Halfword access with addr[0]=1.
  - Word access with addr[1:0]≠0.
- **REQ**:
  - m_valid=1, stall=1.
  - On m_ready: a write goes to DONE; a read goes to RESP.
- **RESP**:
  - stall=1.
  - On m_rvalid: capture m_rdata and go to DONE.
- **DONE**:
  - stall=0; rdata, misaligned and bus_err are driven for this cycle.
  - Always returns to IDLE.
  - The core advances on this edge.
- **Timeout**:
  - A counter clears on entry to REQ and on entry to RESP, and increments each cycle spent in either state.
  - When it reaches TIMEOUT without the awaited event, go to DONE with bus_err=1 and rdata=0.
- **Byte enables** (off=addr[1:0]):
  - byte: 0001<<off.
  - half: 0011<<off.
  - word: 1111.
  - m_be is driven for reads and writes.
- **Store data**:
  - sb: {4{wdata[7:0]}}.
  - sh: {2{wdata[15:0]}}.
  - sw: wdata.
- **Load extract**:
  - Byte lane = m_rdata[8*off +: 8], halfword lane = m_rdata[16*addr[1] +: 16].
  - lb/lh sign-extend; lbu/lhu zero-extend; lw takes the word unchanged.
- When neither mem_read nor mem_write is high: stall=0 and the FSM stays in IDLE.
- m_valid, m_we, m_addr, m_be and m_wdata are 0 outside REQ.

## Timing
- Reset values: state IDLE; timeout counter 0; all outputs 0 (stall follows the combinational rule once rst is released).
- Reset asserted mid-transaction: the FSM returns to IDLE immediately and m_valid drops asynchronously. Any in-flight bus response is ignored.
- Minimum latency, counted in cycles from the access appearing until the DONE cycle:
  - store: 2 (IDLE, REQ, DONE), i.e. 3 cycles of instruction occupancy.
  - load: 3 (IDLE, REQ, RESP, DONE), i.e. 4 cycles of instruction occupancy.
  - error: 1 (IDLE, DONE).
- m_valid stays high and m_addr, m_be, m_we and m_wdata stay stable until accepted.
- m_rvalid is ignored in any state other than RESP, including the accept cycle.
- Back-to-back accesses: the following instruction is sampled in the IDLE cycle right after DONE. No cycle is lost beyond that.
- Worst case without error: TIMEOUT cycles in REQ plus TIMEOUT cycles in RESP.

## Test plan
- **sw**: addr=0x100, wdata=0xDEADBEEF, m_ready=1 → one request with m_addr=0x100, m_be=1111, m_we=1. stall is high for 2 cycles, then DONE.
- **lb**: addr=0x103, memory word 0x80_12_34_56, rvalid one cycle after accept → rdata=0xFFFFFF80. The same access with lbu → rdata=0x00000080.
- **sh**: addr=0x202, wdata=0x0000ABCD → m_be=1100, m_wdata=0xABCDABCD.
- **lw**: addr=0x101 → no m_valid, misaligned pulses for exactly one cycle, stall is high for 1 cycle.
- **Timeout**: m_ready held at 0 with TIMEOUT=15 → m_valid is high for 15 cycles, then bus_err=1, rdata=0, FSM back in IDLE.
- **Reset**: rst asserted while in RESP → m_valid, stall and the outputs go to 0 immediately. A later m_rvalid is ignored, and the next lw completes normally.
